distance_calculator_seq: RTL and testbench

- Sequential, parametrised successor to the combinational KNN distance stage.
- Accepts one query/training-sample pair per handshake and walks the M*N features P lanes per beat through a 2-stage pipeline. Returns a full-precision distance plus the training class label.
- Metric is selectable per transaction: squared Euclidean or Manhattan.
- Sits between the training-memory reader and the k-nearest sorter.

---
 rtl/knn_pkg.sv | 27 ++
 rtl/dist_lane.sv | 45 ++++
 rtl/distance_calculator_seq.sv | 201 ++++++++++++++++++++
 tb/tb_distance_calculator_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// ---------------------------------------------------------------------------
// knn_pkg : shared types and helpers for the KNN distance stage.
//   metric_e   - distance metric selected per transaction
//   state_e    - sequencer states of distance_calculator_seq
//   dist_width - full-precision distance width for an M x N x B sample
// ---------------------------------------------------------------------------
package knn_pkg;

    typedef enum logic {
        METRIC_SQ_EUCL   = 1'b0,
        METRIC_MANHATTAN = 1'b1
    } metric_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Widest squared term is 2B bits; summing M*N of them needs log2(M*N)
    // extra bits, plus one bit of headroom.
    function automatic int dist_width(input int m, input int n, input int b);
        return 2 * b + $clog2(m * n) + 1;
    endfunction

endpackage

// File: rtl/dist_lane.sv
// ---------------------------------------------------------------------------
// dist_lane : combinational per-element distance term.
//   a, b   - unsigned B-bit feature elements
//   metric - METRIC_SQ_EUCL -> |a-b|^2, METRIC_MANHATTAN -> |a-b|
//   en     - lane carries a real element; 0 forces a zero term
//   term   - 2B-bit term, never truncated
// ---------------------------------------------------------------------------
module dist_lane
    import knn_pkg::*;
#(
    parameter int B = 8
) (
    input  logic [B-1:0]   a,
    input  logic [B-1:0]   b,
    input  metric_e        metric,
    input  logic           en,
    output logic [2*B-1:0] term
);

    logic [B-1:0]   diff_s;
    logic [2*B-1:0] wide_s;

    // Compare-then-subtract keeps |a-b| in B bits without wrap.
    always_comb begin
        diff_s = {B{1'b0}};
        wide_s = {(2*B){1'b0}};
        term   = {(2*B){1'b0}};
        if (a >= b) begin
            diff_s = a - b;
        end else begin
            diff_s = b - a;
        end
        wide_s = {{B{1'b0}}, diff_s};
        if (en) begin
            case (metric)
                METRIC_SQ_EUCL:   term = wide_s * wide_s;
                METRIC_MANHATTAN: term = wide_s;
                default:          term = {(2*B){1'b0}};
            endcase
        end else begin
            term = {(2*B){1'b0}};
        end
    end

endmodule

// File: rtl/distance_calculator_seq.sv
// ---------------------------------------------------------------------------
// distance_calculator_seq : sequential KNN distance stage.
// Accepts one query/training pair per in_valid/in_ready handshake, walks the
// M*N elements P lanes per beat through a 2-stage (term, accumulate)
// pipeline, and presents the distance plus the training label on
// out_valid/out_ready.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - request handshake (in_ready only in IDLE)
//   in_data, train_data   - flattened samples, element k at [k*B +: B]
//   train_type            - class label, echoed on data_type
//   metric_sel            - 0 squared Euclidean, 1 Manhattan (sampled at accept)
//   out_valid/out_ready   - result handshake; outputs held while stalled
//   distance              - DW bits, or B bits saturated with KNN_DIST_SAT_EN
//   dist_sat              - only with KNN_DIST_SAT_EN: result was clipped
// Build option: define KNN_DIST_SAT_EN for the saturating B-bit output.
// ---------------------------------------------------------------------------
module distance_calculator_seq
    import knn_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4,
    parameter int B = 8,
    parameter int P = 2,
    parameter int C = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M*N*B-1:0]   in_data,
    input  logic [M*N*B-1:0]   train_data,
    input  logic [C-1:0]       train_type,
    input  logic               metric_sel,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef KNN_DIST_SAT_EN
    output logic [B-1:0]       distance,
    output logic               dist_sat,
`else
    output logic [dist_width(M, N, B)-1:0] distance,
`endif
    output logic [C-1:0]       data_type
);

    localparam int E     = M * N;
    localparam int DW    = dist_width(M, N, B);
    localparam int BEATS = (E + P - 1) / P;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e           state_r, state_nxt_s;
    logic [E*B-1:0]   qry_r, trn_r;
    logic [C-1:0]     type_r;
    metric_e          metric_r;
    logic [BCW-1:0]   beat_r;
    logic             drain_r;
    logic [2*B-1:0]   terms_r [P];
    logic             s1_vld_r;
    logic [DW-1:0]    acc_r;
    logic [DW-1:0]    sum_s;
    logic             accept_s, last_beat_s;
    logic [2*B-1:0]   lane_term_s [P];
    logic             in_ready_r, out_valid_r;
    logic [C-1:0]     data_type_r;
`ifdef KNN_DIST_SAT_EN
    logic [B-1:0]     distance_r;
    logic             dist_sat_r;
`else
    logic [DW-1:0]    distance_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign distance  = distance_r;
    assign data_type = data_type_r;
`ifdef KNN_DIST_SAT_EN
    assign dist_sat  = dist_sat_r;
`endif

    // Lane l of beat k handles element k*P+l; lanes past the end read
    // element 0 and are disabled so they contribute nothing.
    for (genvar l = 0; l < P; l++) begin : g_lane
        logic [B-1:0] a_s, b_s;
        logic         en_s;

        // Select this lane's element pair for the current beat.
        always_comb begin
            int idx;
            idx  = int'(beat_r) * P + l;
            en_s = 1'b0;
            a_s  = {B{1'b0}};
            b_s  = {B{1'b0}};
            if (idx < E) begin
                en_s = 1'b1;
                a_s  = qry_r[idx*B +: B];
                b_s  = trn_r[idx*B +: B];
            end else begin
                en_s = 1'b0;
                a_s  = qry_r[B-1:0];
                b_s  = trn_r[B-1:0];
            end
        end

        dist_lane #(.B(B)) u_lane (
            .a      (a_s),
            .b      (b_s),
            .metric (metric_r),
            .en     (en_s),
            .term   (lane_term_s[l])
        );
    end

    // Adder tree over the registered lane terms, at full accumulator width.
    always_comb begin
        sum_s = {DW{1'b0}};
        for (int l = 0; l < P; l++) begin
            sum_s = sum_s + DW'(terms_r[l]);
        end
    end

    // Sequencer next-state.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = (state_r == IDLE) && in_valid;
        last_beat_s = (beat_r == BCW'(BEATS - 1));
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? RUN : IDLE;
            RUN:     state_nxt_s = last_beat_s ? DRAIN : RUN;
            DRAIN:   state_nxt_s = drain_r ? DONE : DRAIN;
            DONE:    state_nxt_s = out_ready ? IDLE : DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, request capture, pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            qry_r       <= {(E*B){1'b0}};
            trn_r       <= {(E*B){1'b0}};
            type_r      <= {C{1'b0}};
            metric_r    <= METRIC_SQ_EUCL;
            beat_r      <= {BCW{1'b0}};
            drain_r     <= 1'b0;
            for (int l = 0; l < P; l++) terms_r[l] <= {(2*B){1'b0}};
            s1_vld_r    <= 1'b0;
            acc_r       <= {DW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            data_type_r <= {C{1'b0}};
            distance_r  <= '0;
`ifdef KNN_DIST_SAT_EN
            dist_sat_r  <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);

            if (accept_s) begin
                qry_r    <= in_data;
                trn_r    <= train_data;
                type_r   <= train_type;
                metric_r <= metric_e'(metric_sel);
                beat_r   <= {BCW{1'b0}};
                drain_r  <= 1'b0;
            end else if (state_r == RUN) begin
                beat_r   <= beat_r + BCW'(1);
            end else if (state_r == DRAIN) begin
                drain_r  <= ~drain_r;
            end

            // Stage 1: capture lane terms while beats issue.
            for (int l = 0; l < P; l++) terms_r[l] <= lane_term_s[l];
            s1_vld_r <= (state_r == RUN);

            // Stage 2: accumulate; cleared for every new request.
            if (accept_s) begin
                acc_r <= {DW{1'b0}};
            end else if (s1_vld_r) begin
                acc_r <= acc_r + sum_s;
            end

            // Result is final once the second drain cycle is reached.
            if ((state_r == DRAIN) && drain_r) begin
                data_type_r <= type_r;
`ifdef KNN_DIST_SAT_EN
                if (|acc_r[DW-1:B]) begin
                    distance_r <= {B{1'b1}};
                    dist_sat_r <= 1'b1;
                end else begin
                    distance_r <= acc_r[B-1:0];
                    dist_sat_r <= 1'b0;
                end
`else
                distance_r  <= acc_r;
`endif
            end
        end
    end

endmodule

// File: tb/tb_distance_calculator_seq.sv
// ---------------------------------------------------------------------------
// tb_distance_calculator_seq : directed self-checking bench.
// u0: M=2,N=2,P=1 (4 beats)  u1: M=2,N=2,P=2  u2: M=1,N=3,P=2 (partial beat)
// ---------------------------------------------------------------------------
module tb_distance_calculator_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_n  = 0;
    int total_n = 0;
    int lat;

`ifdef KNN_DIST_SAT_EN
    localparam int EXP_BIG = 255;
    localparam int OW = 8;
`else
    localparam int EXP_BIG = 260100;
    localparam int OW = 19;
`endif

    // u0
    logic        in_valid0 = 1'b0, in_ready0, metric0 = 1'b0, out_valid0, out_ready0 = 1'b1;
    logic [31:0] in_data0 = 32'd0, train0 = 32'd0;
    logic [3:0]  type0 = 4'd0, dtype0;
    logic [OW-1:0] dist0;
    // u1
    logic        in_valid1 = 1'b0, in_ready1, metric1 = 1'b0, out_valid1, out_ready1 = 1'b1;
    logic [31:0] in_data1 = 32'd0, train1 = 32'd0;
    logic [3:0]  type1 = 4'd0, dtype1;
    logic [OW-1:0] dist1;
    // u2
    logic        in_valid2 = 1'b0, in_ready2, metric2 = 1'b0, out_valid2, out_ready2 = 1'b1;
    logic [23:0] in_data2 = 24'd0, train2 = 24'd0;
    logic [3:0]  type2 = 4'd0, dtype2;
    logic [OW-1:0] dist2;
`ifdef KNN_DIST_SAT_EN
    logic sat0, sat1, sat2;
`endif

    distance_calculator_seq #(.M(2), .N(2), .B(8), .P(1), .C(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .train_data(train0), .train_type(type0),
        .metric_sel(metric0), .out_valid(out_valid0), .out_ready(out_ready0),
`ifdef KNN_DIST_SAT_EN
        .dist_sat(sat0),
`endif
        .distance(dist0), .data_type(dtype0));

    distance_calculator_seq #(.M(2), .N(2), .B(8), .P(2), .C(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .train_data(train1), .train_type(type1),
        .metric_sel(metric1), .out_valid(out_valid1), .out_ready(out_ready1),
`ifdef KNN_DIST_SAT_EN
        .dist_sat(sat1),
`endif
        .distance(dist1), .data_type(dtype1));

    distance_calculator_seq #(.M(1), .N(3), .B(8), .P(2), .C(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .train_data(train2), .train_type(type2),
        .metric_sel(metric2), .out_valid(out_valid2), .out_ready(out_ready2),
`ifdef KNN_DIST_SAT_EN
        .dist_sat(sat2),
`endif
        .distance(dist2), .data_type(dtype2));

    function automatic logic [31:0] pk(input logic [7:0] e0, input logic [7:0] e1,
                                       input logic [7:0] e2, input logic [7:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) begin
            pass_n++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request on u0 (called #1 after an edge with in_ready0 high),
    // scramble the inputs after accept, and count cycles to out_valid.
    task automatic req0(input logic [31:0] q, input logic [31:0] t, input logic [3:0] ty,
                        input logic m, output int l);
        in_data0 = q; train0 = t; type0 = ty; metric0 = m; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_data0 = ~q; train0 = ~t; type0 = ~ty; metric0 = ~m;
        l = 0;
        while (out_valid0 !== 1'b1 && l < 40) begin
            @(posedge clk); #1; l++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_distance", 32'(dist0), 32'd0);
        chk("rst_data_type", 32'(dtype0), 32'd0);
        chk("rst_in_ready_u2", 32'(in_ready2), 32'd1);

        // Squared Euclidean: 9+16+0+100
        req0(pk(8'd10, 8'd20, 8'd30, 8'd40), pk(8'd13, 8'd16, 8'd30, 8'd50), 4'd3, 1'b0, lat);
        chk("eucl_latency", 32'(lat), 32'd6);
        chk("eucl_distance", 32'(dist0), 32'd125);
        chk("eucl_type", 32'(dtype0), 32'd3);
`ifdef KNN_DIST_SAT_EN
        chk("eucl_sat", 32'(sat0), 32'd0);
`endif
        @(posedge clk); #1;
        chk("eucl_ovalid_fall", 32'(out_valid0), 32'd0);
        chk("eucl_idle_ready", 32'(in_ready0), 32'd1);

        // Manhattan: 3+4+0+10
        req0(pk(8'd10, 8'd20, 8'd30, 8'd40), pk(8'd13, 8'd16, 8'd30, 8'd50), 4'd7, 1'b1, lat);
        chk("manh_latency", 32'(lat), 32'd6);
        chk("manh_distance", 32'(dist0), 32'd17);
        chk("manh_type", 32'(dtype0), 32'd7);
        @(posedge clk); #1;

        // Backpressure: 9+4+1+0 held while a new request is pending
        out_ready0 = 1'b0;
        req0(pk(8'd1, 8'd2, 8'd3, 8'd4), pk(8'd4, 8'd4, 8'd4, 8'd4), 4'd9, 1'b0, lat);
        chk("bp_latency", 32'(lat), 32'd6);
        in_data0 = pk(8'd10, 8'd20, 8'd30, 8'd40); train0 = pk(8'd13, 8'd16, 8'd30, 8'd50);
        type0 = 4'd2; metric0 = 1'b1; in_valid0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_distance", 32'(dist0), 32'd14);
            chk("bp_type", 32'(dtype0), 32'd9);
            chk("bp_in_ready", 32'(in_ready0), 32'd0);
            chk("bp_out_valid", 32'(out_valid0), 32'd1);
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_ovalid", 32'(out_valid0), 32'd0);
        chk("bp_hs_ready", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        chk("bp_accepted", 32'(in_ready0), 32'd0);
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp2_latency", 32'(lat), 32'd6);
        chk("bp2_distance", 32'(dist0), 32'd17);
        chk("bp2_type", 32'(dtype0), 32'd2);
        @(posedge clk); #1;

        // Reset during RUN discards the partial sum
        in_data0 = 32'hFFFF_FFFF; train0 = 32'd0; type0 = 4'd12; metric0 = 1'b0; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ovalid", 32'(out_valid0), 32'd0);
        chk("mid_rst_ready", 32'(in_ready0), 32'd1);
        chk("mid_rst_distance", 32'(dist0), 32'd0);
        req0(pk(8'd10, 8'd20, 8'd30, 8'd40), pk(8'd13, 8'd16, 8'd30, 8'd50), 4'd3, 1'b0, lat);
        chk("post_rst_latency", 32'(lat), 32'd6);
        chk("post_rst_distance", 32'(dist0), 32'd125);
        @(posedge clk); #1;

        // Width corner on P=1 instance
        req0(32'hFFFF_FFFF, 32'd0, 4'd12, 1'b0, lat);
        chk("big_u0_latency", 32'(lat), 32'd6);
        chk("big_u0_distance", 32'(dist0), 32'(EXP_BIG));
        chk("big_u0_type", 32'(dtype0), 32'd12);
`ifdef KNN_DIST_SAT_EN
        chk("big_u0_sat", 32'(sat0), 32'd1);
`endif

        // Width corner, two lanes: 4 * 255^2
        in_data1 = 32'hFFFF_FFFF; train1 = 32'd0; type1 = 4'd5; metric1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_data1 = 32'd0;
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("big_u1_latency", 32'(lat), 32'd4);
        chk("big_u1_distance", 32'(dist1), 32'(EXP_BIG));
        chk("big_u1_type", 32'(dtype1), 32'd5);
`ifdef KNN_DIST_SAT_EN
        chk("big_u1_sat", 32'(sat1), 32'd1);
`endif

        // Partial final beat: 1+4+9, the idle fourth lane adds nothing
        in_data2 = {8'd3, 8'd2, 8'd1}; train2 = 24'd0; type2 = 4'd6; metric2 = 1'b0; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("part_latency", 32'(lat), 32'd4);
        chk("part_distance", 32'(dist2), 32'd14);
        chk("part_type", 32'(dtype2), 32'd6);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
